// File: rtl/rdoq_pkg.sv
// Shared widths and coefficient range for the RDOQ / dequantization datapath.
// Coefficients are 16-bit signed; shifts are 6-bit signed (right 1..31, left 0..15).
package rdoq_pkg;

    localparam int IQ_LEVEL_W      = 16;
    localparam int IQ_COEF_W       = 16;
    localparam int IQ_CNT_W        = 16;
    localparam int SHIFT_W         = 6;

    localparam int COEFF_MIN       = -32768;
    localparam int COEFF_MAX       = 32767;
    localparam int MAX_LEFT_SHIFT  = 15;
    localparam int MAX_RIGHT_SHIFT = 31;

endpackage

// File: rtl/iq_round_shift_clip.sv
// Combinational final dequant stage: rounded right shift or left shift of |level|*scale, then clip and sign.
// Zero latency; no flow control (the enclosing pipeline holds inputs while stalled).
module iq_round_shift_clip
    import rdoq_pkg::*;
#(
    parameter int LEVEL_W = IQ_LEVEL_W,
    parameter int COEF_W  = IQ_COEF_W
) (
    input  logic [LEVEL_W+COEF_W-1:0] prod_i,
    input  logic signed [SHIFT_W-1:0] shift_i,
    input  logic                      sign_i,
    output logic signed [LEVEL_W-1:0] coef_o,
    output logic                      sat_o
);

    localparam int PROD_W = LEVEL_W + COEF_W;
    localparam int WIDE_W = PROD_W + MAX_LEFT_SHIFT + 1;
    localparam int RSH_W  = $clog2(MAX_RIGHT_SHIFT + 1);

    localparam logic [PROD_W:0]   RND_ONE = 1;
    localparam logic [WIDE_W-1:0] POS_LIM = WIDE_W'(COEFF_MAX);
    localparam logic [WIDE_W-1:0] NEG_LIM = WIDE_W'(-COEFF_MIN);

    logic [RSH_W-1:0]   rsh;
    logic [SHIFT_W-1:0] lsh;
    logic [PROD_W:0]    rnd;
    logic [PROD_W:0]    sum;
    logic [WIDE_W-1:0]  r;
    logic [WIDE_W-1:0]  lim;
    logic [LEVEL_W-1:0] mag;

    always_comb begin
        rsh = shift_i[RSH_W-1:0];
        lsh = -shift_i;
        rnd = '0;
        sum = '0;
        if (shift_i > 0) begin
            // Rounding adds half an LSB of the result before truncation.
            rnd = RND_ONE << (rsh - RSH_W'(1));
            sum = {1'b0, prod_i} + rnd;
            r   = WIDE_W'(sum >> rsh);
        end else begin
            r   = WIDE_W'(prod_i) << lsh;
        end
        lim    = sign_i ? NEG_LIM : POS_LIM;
        sat_o  = (r > lim);
        mag    = sat_o ? lim[LEVEL_W-1:0] : r[LEVEL_W-1:0];
        coef_o = sign_i ? -mag : mag;
    end

endmodule

// File: rtl/inverse_quantization_unit.sv
// HEVC coefficient dequantization with per-block clip counting; 3 enabled cycles input to output, 1 beat/cycle.
// Backpressure: single global stall enable, in_ready = !out_valid | out_ready; every stage holds while stalled.
module inverse_quantization_unit
    import rdoq_pkg::*;
#(
    parameter int LEVEL_W = IQ_LEVEL_W,
    parameter int COEF_W  = IQ_COEF_W,
    parameter int CNT_W   = IQ_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [LEVEL_W-1:0] level,
    input  logic [COEF_W-1:0]         dequantCoeff,
    input  logic signed [SHIFT_W-1:0] iShift,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [LEVEL_W-1:0] coeffRecon,
    output logic                      out_sat,
    output logic                      out_last,
    output logic [CNT_W-1:0]          blkSatCount
);

    localparam int PROD_W = LEVEL_W + COEF_W;

    logic                      s1_vld_q;
    logic                      s1_sign_q;
    logic [LEVEL_W-1:0]        s1_mag_q;
    logic [COEF_W-1:0]         s1_coef_q;
    logic signed [SHIFT_W-1:0] s1_shift_q;
    logic                      s1_last_q;

    logic                      s2_vld_q;
    logic                      s2_sign_q;
    logic [PROD_W-1:0]         s2_prod_q;
    logic signed [SHIFT_W-1:0] s2_shift_q;
    logic                      s2_last_q;

    logic                      out_vld_q;
    logic signed [LEVEL_W-1:0] coef_q;
    logic                      sat_q;
    logic                      last_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;

    logic                      en;
    logic                      xfer;
    logic [LEVEL_W-1:0]        mag_in;
    logic [CNT_W-1:0]          blk_sum;
    logic signed [LEVEL_W-1:0] s3_coef;
    logic                      s3_sat;

    assign en       = !out_vld_q || out_ready;
    assign in_ready = en;
    assign xfer     = out_vld_q && out_ready;

    // Magnitude is unsigned so the most negative level maps to 2^(LEVEL_W-1).
    assign mag_in = level[LEVEL_W-1] ? (LEVEL_W'(~level) + LEVEL_W'(1)) : LEVEL_W'(level);

    iq_round_shift_clip #(
        .LEVEL_W (LEVEL_W),
        .COEF_W  (COEF_W)
    ) u_rsc (
        .prod_i  (s2_prod_q),
        .shift_i (s2_shift_q),
        .sign_i  (s2_sign_q),
        .coef_o  (s3_coef),
        .sat_o   (s3_sat)
    );

    always_comb begin
        blk_sum = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(sat_q));
        cnt_d   = cnt_q;
        if (xfer) begin
            cnt_d = last_q ? '0 : blk_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_coef_q  <= '0;
            s1_shift_q <= '0;
            s1_last_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_prod_q  <= '0;
            s2_shift_q <= '0;
            s2_last_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            coef_q     <= '0;
            sat_q      <= 1'b0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (en) begin
                s1_vld_q   <= in_valid;
                s1_sign_q  <= level[LEVEL_W-1];
                s1_mag_q   <= mag_in;
                s1_coef_q  <= dequantCoeff;
                s1_shift_q <= iShift;
                s1_last_q  <= in_last;

                s2_vld_q   <= s1_vld_q;
                s2_sign_q  <= s1_sign_q;
                s2_prod_q  <= PROD_W'(s1_mag_q) * PROD_W'(s1_coef_q);
                s2_shift_q <= s1_shift_q;
                s2_last_q  <= s1_last_q;

                out_vld_q  <= s2_vld_q;
                coef_q     <= s3_coef;
                sat_q      <= s3_sat;
                last_q     <= s2_last_q;
            end
        end
    end

    assign out_valid   = out_vld_q;
    assign coeffRecon  = coef_q;
    assign out_sat     = sat_q;
    assign out_last    = last_q;
    assign blkSatCount = blk_sum;

endmodule

// File: tb/tb_inverse_quantization_unit.sv
// Directed and randomized-handshake bench for inverse_quantization_unit.
module tb_inverse_quantization_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] level;
    logic [15:0]        dequantCoeff;
    logic signed [5:0]  iShift;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] coeffRecon;
    logic               out_sat;
    logic               out_last;
    logic [15:0]        blkSatCount;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int c;
        int s;
        int l;
        int b;
    } exp_t;

    exp_t exp_q[$];
    int   st_lvl [1024];
    int   st_cf  [1024];
    int   st_sh  [1024];
    int   st_lst [1024];
    int   obs_c  [1024];
    int   obs_s  [1024];
    int   obs_l  [1024];
    int   obs_b  [1024];

    // level, dequantCoeff, iShift, expected coeffRecon, expected out_sat
    int dir_tbl [14][5] = '{
        '{     5,    40,   1,    100, 0},
        '{    -7,    51,   2,    -89, 0},
        '{     3,     1,   1,      2, 0},
        '{-32768,    72,  -4, -32768, 1},
        '{ 32767,    72,  -4,  32767, 1},
        '{     0,   500, -15,      0, 0},
        '{    -3,     1,   1,     -2, 0},
        '{  1000,  1000,   0,  32767, 1},
        '{-32768,     1,   0, -32768, 0},
        '{ 32767,     2,   1,  32767, 0},
        '{ 32767,     1,  -1,  32767, 1},
        '{-16384,     1,  -1, -32768, 0},
        '{   100, 65535,  31,      0, 0},
        '{-32768, 65535,  16, -32768, 0}
    };

    inverse_quantization_unit dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .level        (level),
        .dequantCoeff (dequantCoeff),
        .iShift       (iShift),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .coeffRecon   (coeffRecon),
        .out_sat      (out_sat),
        .out_last     (out_last),
        .blkSatCount  (blkSatCount)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void iq_model(input int lvl, input int cf, input int sh, output int rc, output int sat);
        longint m;
        longint r;
        longint lim;
        m = longint'(lvl < 0 ? -lvl : lvl) * longint'(cf);
        if (sh > 0) r = (m + (longint'(1) << (sh - 1))) >> sh;
        else        r = m << (-sh);
        lim = (lvl < 0) ? 64'sd32768 : 64'sd32767;
        sat = (r > lim) ? 1 : 0;
        if (r > lim) r = lim;
        rc = (lvl < 0) ? -int'(r) : int'(r);
    endfunction

    task automatic drive_beat(input int lvl, input int cf, input int sh, input int lst);
        level        = 16'(lvl);
        dequantCoeff = 16'(cf);
        iShift       = 6'(sh);
        in_last      = (lst != 0);
    endtask

    // One isolated beat with out_ready held high; checks latency and all output fields.
    task automatic send_single(input int lvl, input int cf, input int sh, input int lst,
                               input int ec, input int es, input int eb);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_beat(lvl, cf, sh, lst);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check_eq($sformatf("latency(%0d,%0d,%0d)", lvl, cf, sh), lat, 3);
        check_eq($sformatf("coeff(%0d,%0d,%0d)", lvl, cf, sh), coeffRecon, ec);
        check_eq($sformatf("sat(%0d,%0d,%0d)", lvl, cf, sh), out_sat, es);
        check_eq("single_last", out_last, lst);
        check_eq("single_blk", blkSatCount, eb);
    endtask

    // Pushes st_* beats through with random valid/ready; scoreboard against iq_model.
    task automatic run_stream(input int n, input int pv, input int pr);
        int   cnt;
        int   rc;
        int   rs;
        int   sent;
        int   got;
        int   cyc;
        int   seen;
        bit   acc_in;
        bit   stall_prev;
        logic [31:0] hold;
        exp_t e;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            iq_model(st_lvl[i], st_cf[i], st_sh[i], rc, rs);
            e.c = rc;
            e.s = rs;
            e.l = st_lst[i];
            e.b = cnt + rs;
            exp_q.push_back(e);
            cnt = (st_lst[i] != 0) ? 0 : cnt + rs;
        end
        sent = 0;
        got = 0;
        cyc = 0;
        acc_in = 1'b0;
        stall_prev = 1'b0;
        hold = '0;
        in_valid = 1'b0;
        while (got < n && cyc < 40 * n + 100) begin
            @(negedge clk);
            cyc++;
            if (acc_in) begin
                sent++;
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(99) < pr);
            if (sent < n && !in_valid) in_valid = ($urandom_range(99) < pv);
            if (in_valid) drive_beat(st_lvl[sent], st_cf[sent], st_sh[sent], st_lst[sent]);
            #1;
            if (stall_prev) check_eq("stall_hold", {13'd0, out_valid, out_sat, out_last, coeffRecon}, hold);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("coeff[%0d]", got), coeffRecon, e.c);
                    check_eq($sformatf("sat[%0d]", got), out_sat, e.s);
                    check_eq($sformatf("last[%0d]", got), out_last, e.l);
                    check_eq($sformatf("blk[%0d]", got), blkSatCount, e.b);
                    obs_c[got] = coeffRecon;
                    obs_s[got] = out_sat;
                    obs_l[got] = out_last;
                    obs_b[got] = blkSatCount;
                    got++;
                end
            end
            stall_prev = out_valid && !out_ready;
            hold = {13'd0, out_valid, out_sat, out_last, coeffRecon};
            acc_in = in_valid && in_ready;
        end
        check_eq("beats_out", got, n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("no_extra_beats", seen, 0);
        exp_q.delete();
    endtask

    initial begin
        int seen;
        int pick;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive_beat(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_coeff", coeffRecon, 0);
        check_eq("rst_sat", out_sat, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_blk", blkSatCount, 0);
        check_eq("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++)
            send_single(dir_tbl[i][0], dir_tbl[i][1], dir_tbl[i][2], 1,
                        dir_tbl[i][3], dir_tbl[i][4], dir_tbl[i][4]);

        // 8-beat block with beats 2 and 5 clipped, then a one-beat block.
        for (int i = 0; i < 9; i++) begin
            st_lvl[i] = (i == 1 || i == 4) ? 32767 : 5;
            st_cf[i]  = (i == 1 || i == 4) ? 72 : 40;
            st_sh[i]  = (i == 1 || i == 4) ? -4 : 1;
            st_lst[i] = (i == 7) ? 1 : 0;
        end
        st_lvl[8] = -32768;
        st_cf[8]  = 72;
        st_sh[8]  = -4;
        st_lst[8] = 1;
        run_stream(9, 100, 100);
        check_eq("blk_beat2", obs_b[1], 1);
        check_eq("coeff_beat2", obs_c[1], 32767);
        check_eq("coeff_beat1", obs_c[0], 100);
        check_eq("blk_beat5", obs_b[4], 2);
        check_eq("blk_beat8", obs_b[7], 2);
        check_eq("last_beat8", obs_l[7], 1);
        check_eq("last_beat7", obs_l[6], 0);
        check_eq("blk_next_block", obs_b[8], 1);
        check_eq("sat_next_block", obs_s[8], 1);

        // Reset with a nonzero counter and two beats in flight.
        send_single(32767, 72, -4, 0, 32767, 1, 1);
        @(negedge clk);
        in_valid = 1'b1;
        drive_beat(5, 40, 1, 0);
        @(negedge clk);
        drive_beat(-7, 51, 2, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_blk", blkSatCount, 0);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("midrst_no_output", seen, 0);
        send_single(-32768, 72, -4, 1, -32768, 1, 1);

        for (int i = 0; i < 1000; i++) begin
            pick = $urandom_range(9);
            if (pick == 0)      st_lvl[i] = -32768;
            else if (pick == 1) st_lvl[i] = 32767;
            else if (pick == 2) st_lvl[i] = 0;
            else if (pick == 3) st_lvl[i] = $urandom_range(40) - 20;
            else                st_lvl[i] = $urandom_range(65535) - 32768;
            st_cf[i]  = (pick > 6) ? $urandom_range(100) : $urandom_range(65535);
            st_sh[i]  = $urandom_range(46) - 15;
            st_lst[i] = ($urandom_range(7) == 0) ? 1 : 0;
        end
        run_stream(1000, 70, 65);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
